// File: rtl/garage_door_ctrl_v2_if.sv
// Signal bundle between the door controller and its button, limit/obstruction sensors and motor driver.
interface garage_door_ctrl_v2_if;
    logic       Activate;
    logic       Up_Max;
    logic       Dn_Max;
    logic       Obstruct;
    logic       UP_M;
    logic       DN_M;
    logic       Fault;
    logic [2:0] State;

    modport master (output Activate, Up_Max, Dn_Max, Obstruct,
                    input  UP_M, DN_M, Fault, State);
    modport slave  (input  Activate, Up_Max, Dn_Max, Obstruct,
                    output UP_M, DN_M, Fault, State);
endinterface

// File: rtl/garage_door_ctrl_v2.sv
// Garage door motor controller: debounced button, stop/reverse, obstruction reverse, travel timeout, limit resync.
// Optional auto-close from OPEN is enabled by defining AUTO_CLOSE_EN.
module garage_door_ctrl_v2 #(
    parameter int DB_CYCLES   = 4,
    parameter int TRAVEL_MAX  = 1000,
    parameter int CLOSE_DELAY = 500,
    parameter int CNT_W       = 16
) (
    input  logic                 CLK,
    input  logic                 RST,
    garage_door_ctrl_v2_if.slave io
);
    typedef enum logic [2:0] {
        CLOSED = 3'b000,
        MV_UP  = 3'b001,
        OPEN   = 3'b010,
        MV_DN  = 3'b011,
        STOP   = 3'b100,
        FAULT  = 3'b101
    } state_t;

    localparam int DB_W    = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam int CNT_LIM = (TRAVEL_MAX > CLOSE_DELAY) ? TRAVEL_MAX : CLOSE_DELAY;
    localparam logic [CNT_W-1:0] CNT_SAT     = CNT_W'(CNT_LIM - 1);
    localparam logic [CNT_W-1:0] TRAVEL_LAST = CNT_W'(TRAVEL_MAX - 1);
`ifdef AUTO_CLOSE_EN
    localparam logic [CNT_W-1:0] CLOSE_LAST  = CNT_W'(CLOSE_DELAY - 1);
`endif

    state_t            st, nxt;
    logic              db, db_d, press;
    logic [DB_W-1:0]   db_cnt;
    logic [CNT_W-1:0]  cnt;
    logic              dir_up;
    logic              up_m, dn_m, fault;
    logic              moving;

    assign moving = (st == MV_UP) || (st == MV_DN);

    // Debounced level flips only after DB_CYCLES consecutive disagreeing samples.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            db     <= 1'b0;
            db_d   <= 1'b0;
            press  <= 1'b0;
            db_cnt <= '0;
        end else begin
            db_d  <= db;
            press <= db & ~db_d;
            if (io.Activate == db) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_W'(DB_CYCLES - 1)) begin
                db     <= io.Activate;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + DB_W'(1);
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) st <= CLOSED;
        else      st <= nxt;
    end

    always_comb begin
        nxt = st;
        case (st)
            CLOSED: begin
                if (io.Up_Max && !io.Dn_Max) nxt = OPEN;
                else if (press)              nxt = MV_UP;
            end
            MV_UP: begin
                if (io.Up_Max)               nxt = OPEN;
                else if (cnt == TRAVEL_LAST) nxt = FAULT;
                else if (press)              nxt = STOP;
            end
            OPEN: begin
                if (io.Dn_Max && !io.Up_Max)     nxt = CLOSED;
                else if (press && !io.Obstruct)  nxt = MV_DN;
`ifdef AUTO_CLOSE_EN
                else if (!io.Obstruct && cnt == CLOSE_LAST) nxt = MV_DN;
`endif
            end
            MV_DN: begin
                if (io.Dn_Max)               nxt = CLOSED;
                else if (io.Obstruct)        nxt = MV_UP;
                else if (cnt == TRAVEL_LAST) nxt = FAULT;
                else if (press)              nxt = STOP;
            end
            STOP: begin
                if (press && !dir_up)                   nxt = MV_UP;
                else if (press && dir_up && !io.Obstruct) nxt = MV_DN;
            end
            FAULT:   nxt = FAULT;
            default: nxt = FAULT;
        endcase
        if (io.Up_Max && io.Dn_Max) nxt = FAULT;
    end

    // Any state change restarts the shared counter, so each travel segment gets a fresh budget.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            cnt <= '0;
        end else if (nxt != st) begin
            cnt <= '0;
        end else if (moving) begin
            cnt <= (cnt == CNT_SAT) ? cnt : cnt + CNT_W'(1);
`ifdef AUTO_CLOSE_EN
        end else if (st == OPEN) begin
            cnt <= io.Obstruct ? '0 : ((cnt == CNT_SAT) ? cnt : cnt + CNT_W'(1));
`endif
        end else begin
            cnt <= '0;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST)                              dir_up <= 1'b0;
        else if (nxt == MV_UP && st != MV_UP)  dir_up <= 1'b1;
        else if (nxt == MV_DN && st != MV_DN)  dir_up <= 1'b0;
    end

    // Outputs registered from the next state so they line up with the state register.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            up_m  <= 1'b0;
            dn_m  <= 1'b0;
            fault <= 1'b0;
        end else begin
            up_m  <= (nxt == MV_UP);
            dn_m  <= (nxt == MV_DN);
            fault <= (nxt == FAULT);
        end
    end

    assign io.UP_M  = up_m;
    assign io.DN_M  = dn_m;
    assign io.Fault = fault;
    assign io.State = st;
endmodule

// File: tb/tb_garage_door_ctrl_v2.sv
// Directed bench for garage_door_ctrl_v2 with a cycle-level reference model of the door behaviour.
module tb_garage_door_ctrl_v2;
    localparam int DB = 2;
    localparam int TM = 20;
    localparam int CD = 10;
`ifdef AUTO_CLOSE_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic CLK;
    logic RST;
    garage_door_ctrl_v2_if io();

    garage_door_ctrl_v2 #(.DB_CYCLES(DB), .TRAVEL_MAX(TM), .CLOSE_DELAY(CD), .CNT_W(16))
        dut (.CLK(CLK), .RST(RST), .io(io));

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;
    bit run_cmp = 1'b0;

    task automatic chk(input string nm, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d at %0t", nm, got, exp, $time);
        end
    endtask

    // Model: state codes are the published encodings; timing is tracked by edge timestamps and segment lengths.
    int m_st, m_run, m_rise, m_edge, m_seg, m_idle;
    bit m_db, m_dir_up;
    int n_st, n_run, n_rise, n_edge, n_seg, n_idle, seg_now, idle_now;
    bit n_db, n_dir_up, prs, u, d, o;

    always_comb begin
        n_edge   = m_edge + 1;
        n_run    = m_run;
        n_db     = m_db;
        n_rise   = m_rise;
        n_dir_up = m_dir_up;
        u        = io.Up_Max;
        d        = io.Dn_Max;
        o        = io.Obstruct;
        prs      = (m_rise == n_edge - 2);
        if (io.Activate != m_db) begin
            n_run = m_run + 1;
            if (n_run == DB) begin
                n_db  = io.Activate;
                n_run = 0;
                if (io.Activate) n_rise = n_edge;
            end
        end else begin
            n_run = 0;
        end
        seg_now  = m_seg + 1;
        idle_now = o ? 0 : m_idle + 1;
        n_st = m_st;
        case (m_st)
            0: if (u && !d) n_st = 2; else if (prs) n_st = 1;
            1: if (u) n_st = 2; else if (seg_now == TM) n_st = 5; else if (prs) n_st = 4;
            2: if (d && !u) n_st = 0; else if (prs && !o) n_st = 3; else if (AUTO && !o && idle_now == CD) n_st = 3;
            3: if (d) n_st = 0; else if (o) n_st = 1; else if (seg_now == TM) n_st = 5; else if (prs) n_st = 4;
            4: if (prs && !m_dir_up) n_st = 1; else if (prs && !o) n_st = 3;
            default: n_st = 5;
        endcase
        if (u && d) n_st = 5;
        n_seg  = (n_st != m_st) ? 0 : ((m_st == 1 || m_st == 3) ? seg_now : 0);
        n_idle = (n_st != m_st) ? 0 : ((m_st == 2) ? idle_now : 0);
        if (n_st == 1 && m_st != 1) n_dir_up = 1'b1;
        if (n_st == 3 && m_st != 3) n_dir_up = 1'b0;
    end

    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            m_st <= 0; m_run <= 0; m_rise <= -100; m_edge <= 0;
            m_seg <= 0; m_idle <= 0; m_db <= 1'b0; m_dir_up <= 1'b0;
        end else begin
            m_st <= n_st; m_run <= n_run; m_rise <= n_rise; m_edge <= n_edge;
            m_seg <= n_seg; m_idle <= n_idle; m_db <= n_db; m_dir_up <= n_dir_up;
        end
    end

    always @(negedge CLK) begin
        if (run_cmp)
            chk("cyc", {io.State, io.UP_M, io.DN_M, io.Fault},
                {m_st[2:0], (m_st == 1), (m_st == 3), (m_st == 5)});
    end

    task automatic step(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic press_btn();
        io.Activate = 1'b1;
        step(2);
        io.Activate = 1'b0;
        step(2);
    endtask

    initial begin
        RST = 1'b0;
        io.Activate = 1'b0; io.Up_Max = 1'b0; io.Dn_Max = 1'b1; io.Obstruct = 1'b0;
        step(1);
        run_cmp = 1'b1;
        step(2);
        chk("rst_state", io.State, 0);
        chk("rst_outs", {io.UP_M, io.DN_M, io.Fault}, 0);
        RST = 1'b1;

        // Open: press latency is DB_CYCLES+1 edges after the first high sample.
        io.Activate = 1'b1;
        step(3);
        io.Activate = 1'b0;
        chk("pre_latency", io.State, 0);
        step(1);
        chk("open_start", {io.State, io.UP_M, io.DN_M}, 5'b001_1_0);
        io.Dn_Max = 1'b0;
        step(9);
        io.Up_Max = 1'b1;
        step(1);
        chk("open_reached", {io.State, io.UP_M}, 4'b010_0);

        // Single-sample pulse is filtered; 1-0-1-1 glitch gives one press.
        io.Activate = 1'b1; step(1);
        io.Activate = 1'b0; io.Up_Max = 1'b0; step(5);
        chk("pulse_ignored", io.State, 2);
        io.Activate = 1'b1; step(1);
        io.Activate = 1'b0; step(1);
        io.Activate = 1'b1; step(2);
        io.Activate = 1'b0; step(1);
        chk("glitch_pending", io.State, 2);
        step(1);
        chk("glitch_press", {io.State, io.DN_M}, 4'b011_1);

        // Obstruction in motion cycle 5 reverses; fresh 20-cycle budget then times out.
        step(4);
        io.Obstruct = 1'b1;
        step(1);
        chk("reverse", {io.State, io.UP_M, io.DN_M}, 5'b001_1_0);
        step(1);
        io.Obstruct = 1'b0;
        step(18);
        chk("up_before_timeout", io.State, 1);
        step(1);
        chk("timeout", {io.State, io.UP_M, io.DN_M, io.Fault}, 6'b101_0_0_1);
        press_btn();
        chk("fault_absorb", {io.State, io.Fault}, 4'b101_1);

        // Reset clears FAULT; stop and resume in the opposite direction.
        RST = 1'b0; step(1);
        chk("fault_reset", {io.State, io.Fault}, 4'b000_0);
        io.Dn_Max = 1'b1; io.Up_Max = 1'b0;
        RST = 1'b1;
        press_btn();
        chk("press_up", {io.State, io.UP_M}, 4'b001_1);
        io.Dn_Max = 1'b0;
        press_btn();
        chk("stop", {io.State, io.UP_M, io.DN_M}, 5'b100_0_0);
        press_btn();
        chk("resume_down", {io.State, io.DN_M}, 4'b011_1);
        io.Dn_Max = 1'b1; step(1);
        chk("closed_limit", {io.State, io.DN_M}, 4'b000_0);

        // Resync to OPEN, then both limits -> FAULT.
        io.Dn_Max = 1'b0; io.Up_Max = 1'b1; step(1);
        chk("resync_open", io.State, 2);
        io.Dn_Max = 1'b1; step(1);
        chk("both_limits", {io.State, io.Fault}, 4'b101_1);

        RST = 1'b0; step(1);
        io.Dn_Max = 1'b0; io.Up_Max = 1'b1;
        RST = 1'b1; step(1);
        chk("reopen", io.State, 2);
`ifdef AUTO_CLOSE_EN
        step(5);
        io.Obstruct = 1'b1; step(1);
        io.Obstruct = 1'b0; step(9);
        chk("autoclose_wait", io.State, 2);
        step(1);
        chk("autoclose", {io.State, io.DN_M}, 4'b011_1);
`else
        step(30);
        chk("open_hold", {io.State, io.DN_M}, 4'b010_0);
`endif
        step(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
